// File: rtl/alu_iter_unit.sv
// alu_iter_unit: RV32I ALU decode-and-execute with an iterative shifter.
//
// Decodes alu_op/funct3/funct7b5/opb5 into a 4-bit operation code and runs it.
// Single-cycle ops finish on the accept edge. Shifts then take
// ceil(shamt/SHIFT_STEP) more edges. Undecodable requests produce result 0 and
// raise illegal; they never drive X.
//
// Ports
//   clk, reset_n             clock, async active-low reset
//   in_valid / in_ready      request handshake (in_ready high only in IDLE)
//   kill                     synchronous abort, overrides everything else
//   alu_op, funct3,
//   funct7b5, opb5           decode inputs
//   src_a, src_b             operands; shamt = src_b[$clog2(XLEN)-1:0]
//   out_valid / out_ready    result handshake
//   result, zero,
//   alu_ctrl, illegal        held outputs of the completed operation
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// SHIFT | iterating a shift, SHIFT_STEP bits per cycle
// DONE  | result held, out_valid = 1 until out_ready
module alu_iter_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            kill,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            opb5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW:0] STEP_W = (SW+1)'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state;
  logic [SW-1:0]   remaining;
  logic [3:0]      dec_ctrl;
  logic            dec_is_shift;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] exec_res;
  logic [SW-1:0]   step;
  logic [SW-1:0]   rem_next;
  logic [XLEN-1:0] shift_next;

  assign shamt = src_b[SW-1:0];

  always_comb begin
    dec_ctrl = OP_ILL;
    case (alu_op)
      2'b00: dec_ctrl = OP_ADD;
      2'b01: dec_ctrl = OP_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  dec_ctrl = (opb5 & funct7b5) ? OP_SUB : OP_ADD;
          3'b001:  dec_ctrl = OP_SLL;
          3'b010:  dec_ctrl = OP_SLT;
          3'b011:  dec_ctrl = OP_SLTU;
          3'b100:  dec_ctrl = OP_XOR;
          3'b101:  dec_ctrl = funct7b5 ? OP_SRA : OP_SRL;
          3'b110:  dec_ctrl = OP_OR;
          default: dec_ctrl = OP_AND;
        endcase
      end
      default: dec_ctrl = OP_ILL;
    endcase
  end

  assign dec_is_shift = (dec_ctrl == OP_SRL) || (dec_ctrl == OP_SLL) || (dec_ctrl == OP_SRA);

  // Shifts only land here with shamt = 0, so they pass src_a through.
  always_comb begin
    exec_res = '0;
    case (dec_ctrl)
      OP_ADD:  exec_res = src_a + src_b;
      OP_SUB:  exec_res = src_a - src_b;
      OP_AND:  exec_res = src_a & src_b;
      OP_OR:   exec_res = src_a | src_b;
      OP_XOR:  exec_res = src_a ^ src_b;
      OP_SLT:  exec_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: exec_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_SRL, OP_SLL, OP_SRA: exec_res = src_a;
      default: exec_res = '0;
    endcase
  end

  // Compare in SW+1 bits so SHIFT_STEP = XLEN still works; in that case the
  // first branch is always taken.
  always_comb begin
    if ({1'b0, remaining} < STEP_W) step = remaining;
    else                            step = STEP_W[SW-1:0];
    rem_next = remaining - step;
    case (alu_ctrl)
      OP_SLL:  shift_next = result << step;
      // The shift register's MSB stays equal to the original sign bit, so an
      // arithmetic shift of the partial result fills correctly every step.
      OP_SRA:  shift_next = $unsigned($signed(result) >>> step);
      default: shift_next = result >> step;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      alu_ctrl  <= OP_ADD;
      illegal   <= 1'b0;
      remaining <= '0;
    end else if (kill) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            alu_ctrl <= dec_ctrl;
            illegal  <= (dec_ctrl == OP_ILL);
            in_ready <= 1'b0;
            if (dec_is_shift && (shamt != '0)) begin
              result    <= src_a;
              remaining <= shamt;
              state     <= S_SHIFT;
            end else begin
              result    <= exec_res;
              zero      <= (exec_res == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          result    <= shift_next;
          remaining <= rem_next;
          if (rem_next == '0) begin
            zero      <= (shift_next == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_unit.sv
// tb_alu_iter_unit: scoreboard bench for alu_iter_unit.
// Main instance uses SHIFT_STEP=1; a second instance with SHIFT_STEP=8 covers
// the multi-bit step latency. Latency is counted in edges, the accept edge
// included, until out_valid is observed high.
module tb_alu_iter_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid, in_valid8;
  logic            in_ready, in_ready8;
  logic            kill;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7b5, opb5;
  logic [XLEN-1:0] src_a, src_b;
  logic            out_valid, out_valid8;
  logic            out_ready, out_ready8;
  logic [XLEN-1:0] result, result8;
  logic            zero, zero8;
  logic [3:0]      alu_ctrl, alu_ctrl8;
  logic            illegal, illegal8;

  always #5 clk = ~clk;

  alu_iter_unit #(.XLEN(XLEN), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .kill(kill), .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5),
    .opb5(opb5), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .alu_ctrl(alu_ctrl),
    .illegal(illegal)
  );

  alu_iter_unit #(.XLEN(XLEN), .SHIFT_STEP(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .kill(kill), .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5),
    .opb5(opb5), .src_a(src_a), .src_b(src_b), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .zero(zero8), .alu_ctrl(alu_ctrl8),
    .illegal(illegal8)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [3:0]  ctrl;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic f7, input logic o5,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int stp);
    exp_t e;
    logic [4:0] sh;
    sh = b[4:0];
    e.ill = 1'b0;
    e.res = 32'd0;
    e.ctrl = 4'hF;
    if (op == 2'b00) e.ctrl = 4'h0;
    else if (op == 2'b01) e.ctrl = 4'h1;
    else if (op == 2'b10) begin
      case (f3)
        3'd0: e.ctrl = (o5 && f7) ? 4'h1 : 4'h0;
        3'd1: e.ctrl = 4'h6;
        3'd2: e.ctrl = 4'h8;
        3'd3: e.ctrl = 4'h9;
        3'd4: e.ctrl = 4'h4;
        3'd5: e.ctrl = f7 ? 4'h7 : 4'h5;
        3'd6: e.ctrl = 4'h3;
        default: e.ctrl = 4'h2;
      endcase
    end
    case (e.ctrl)
      4'h0: e.res = a + b;
      4'h1: e.res = a - b;
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = a >> sh;
      4'h6: e.res = a << sh;
      4'h7: e.res = $unsigned($signed(a) >>> sh);
      4'h8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: e.res = (a < b) ? 32'd1 : 32'd0;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'd0);
    if ((e.ctrl == 4'h5 || e.ctrl == 4'h6 || e.ctrl == 4'h7) && sh != 5'd0)
      e.lat = 1 + (int'(sh) + stp - 1) / stp;
    else
      e.lat = 1;
    return e;
  endfunction

  task automatic set_ins(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic o5, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct3 = f3; funct7b5 = f7; opb5 = o5; src_a = a; src_b = b;
  endtask

  task automatic scramble();
    alu_op = 2'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
    opb5 = 1'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic o5, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    exp_t e;
    int lat;
    sbq.push_back(model(op, f3, f7, o5, a, b, 1));
    @(negedge clk);
    set_ins(op, f3, f7, o5, a, b);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sbq.pop_front();
    check("out_valid", 64'(out_valid), 64'd1);
    check("result", 64'(result), 64'(e.res));
    check("zero", 64'(zero), 64'(e.z));
    check("alu_ctrl", 64'(alu_ctrl), 64'(e.ctrl));
    check("illegal", 64'(illegal), 64'(e.ill));
    check("latency", 64'(lat), 64'(e.lat));
    check("in_ready_busy", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", 64'(result), 64'(e.res));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    exp_t e;
    int lat;
    bit seen;
    reset_n = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0; kill = 1'b0;
    out_ready = 1'b0; out_ready8 = 1'b0;
    set_ins(2'b00, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    reset_n = 1'b1;

    run_op(2'b10, 3'd0, 1'b1, 1'b1, 32'd5, 32'd7, 0);
    run_op(2'b10, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 0);
    run_op(2'b01, 3'd0, 1'b0, 1'b0, 32'd9, 32'd9, 0);
    run_op(2'b10, 3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd31, 0);
    run_op(2'b10, 3'd5, 1'b0, 1'b1, 32'h8000_0000, 32'd31, 0);
    run_op(2'b10, 3'd1, 1'b0, 1'b1, 32'h1234_5678, 32'd32, 0);
    run_op(2'b10, 3'd1, 1'b0, 1'b1, 32'h0000_0003, 32'd4, 0);
    run_op(2'b10, 3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b10, 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b11, 3'd0, 1'b0, 1'b0, 32'd3, 32'd4, 10);
    run_op(2'b10, 3'd6, 1'b0, 1'b1, 32'hF0F0_0000, 32'h0000_0F0F, 10);
    run_op(2'b10, 3'd4, 1'b0, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0);
    run_op(2'b10, 3'd7, 1'b0, 1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    for (int i = 0; i < 24; i++)
      run_op(2'($urandom_range(0, 3)), 3'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, 0);

    // SHIFT_STEP=8 instance: SRA shamt 31
    e = model(2'b10, 3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd31, 8);
    @(negedge clk);
    set_ins(2'b10, 3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd31);
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    scramble();
    lat = 1;
    while (!out_valid8 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("s8_valid", 64'(out_valid8), 64'd1);
    check("s8_result", 64'(result8), 64'(e.res));
    check("s8_latency", 64'(lat), 64'(e.lat));
    check("s8_ctrl", 64'(alu_ctrl8), 64'(e.ctrl));
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    check("s8_release", 64'(out_valid8), 64'd0);

    // kill mid-shift
    @(negedge clk);
    set_ins(2'b10, 3'd5, 1'b0, 1'b1, 32'hFFFF_0000, 32'd20);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check("kill_in_ready", 64'(in_ready), 64'd1);
    check("kill_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("kill_no_result", 64'(seen), 64'd0);

    // kill with in_valid in IDLE
    @(negedge clk);
    set_ins(2'b00, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2);
    in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("killidle_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("killidle_valid", 64'(out_valid), 64'd0);

    // async reset mid-shift
    @(negedge clk);
    set_ins(2'b10, 3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd31);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_result", 64'(result), 64'd0);
    check("arst_ctrl", 64'(alu_ctrl), 64'd0);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(out_valid), 64'd0);

    // unit still works after reset
    run_op(2'b00, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
